cereal_rx: RTL

Serial receiver that consumes the single-wire output of the `cereal` transmitter and recovers the bytes. It is the downstream stage of the ROM/splitter/`cereal` transmit path. It is used for on-board loopback checking and as the receive side of the link. Each received frame is delivered as one byte with a single-cycle valid strobe; malformed frames are flagged.

---
 rtl/cereal_pkg.sv | 22 ++
 rtl/rx_baud_ctr.sv | 27 ++
 rtl/cereal_rx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cereal_pkg.sv
// Definitions shared by the cereal transmitter and receiver: frame size, idle level, receive FSM
// states and the parity helper.
package cereal_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // StParity is only reachable when CEREAL_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/rx_baud_ctr.sv
// Loadable down-counter that paces bit sampling. It holds at zero, and expired is high while the
// count is zero.
module rx_baud_ctr #(
  parameter int unsigned Width = 13
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/cereal_rx.sv
// Serial receiver for the cereal link: 8N1 frames, or 8E1 frames when CEREAL_RX_PARITY_EN is
// defined. Each good byte is delivered with a one-cycle valid strobe.
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastIdx = 3'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic rx_meta_q, rx_s_q;
  logic rx_s;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic valid_q, valid_d;
  logic frame_err_q, frame_err_d;
  logic cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic cnt_expired;
`ifdef CEREAL_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  // rx is asynchronous; both flops rest at the idle level so reset never looks like a start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_s_q    <= IDLE_LEVEL;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx_s = rx_s_q;

  rx_baud_ctr #(
    .Width(CntW)
  ) u_baud_ctr (
    .sysclk  (sysclk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .expired (cnt_expired)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef CEREAL_RX_PARITY_EN
  always_ff @(posedge sysclk) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    bit_idx_d    = bit_idx_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = FullLoad;
`ifdef CEREAL_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_s != IDLE_LEVEL) begin
          // First sample lands mid start bit.
          cnt_load     = 1'b1;
          cnt_load_val = HalfLoad;
          state_d      = StStart;
        end
      end

      StStart: begin
        if (cnt_expired) begin
          if (rx_s == IDLE_LEVEL) begin
            state_d = StIdle;
          end else begin
            cnt_load  = 1'b1;
            bit_idx_d = '0;
`ifdef CEREAL_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            state_d   = StData;
          end
        end
      end

      StData: begin
        if (cnt_expired) begin
          shreg_d[bit_idx_q] = rx_s;
          cnt_load           = 1'b1;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == LastIdx) begin
`ifdef CEREAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end

`ifdef CEREAL_RX_PARITY_EN
      StParity: begin
        if (cnt_expired) begin
          par_bad_d = (rx_s != even_parity(shreg_q));
          cnt_load  = 1'b1;
          state_d   = StStop;
        end
      end
`endif

      StStop: begin
        if (cnt_expired) begin
          if (rx_s == IDLE_LEVEL) begin
            state_d = StIdle;
`ifdef CEREAL_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shreg_q;
            valid_d = 1'b1;
`endif
          end else begin
            // A low stop bit takes priority over any parity mismatch.
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end

      StWaitHigh: begin
        if (rx_s == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);
`ifdef CEREAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
